// File: rtl/cache_trace_arbiter.sv
// Round-robin arbiter sharing the cache-model trace port among NUM_REQ address sources.
// One access in flight: accept, one-cycle issue strobe, wait for updated or timeout, report.
module cache_trace_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 10,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      trace_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      updated,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      done_valid,
   output logic [ID_W-1:0]           done_id,
   output logic                      done_err,
   output logic                      timeout_err,
   output logic [CNT_W-1:0]          issued_count
);

   localparam int WAIT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                trace_ready_q, trace_ready_d;
   logic                busy_q, busy_d;
   logic                done_valid_q, done_valid_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic                done_err_q, done_err_d;
   logic                timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]    issued_count_q, issued_count_d;

   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [ADDR_W-1:0]   win_addr;

   // Search starts just after the last winner and wraps, giving rotating priority.
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win_id    = '0;
      win_addr  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + k) % NUM_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
            win_addr  = req_addr[idx*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && win_found) begin
         req_ready = NUM_REQ'(1) << win_id;
      end
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      mem_addr_d     = mem_addr_q;
      grant_id_d     = grant_id_q;
      wait_cnt_d     = wait_cnt_q;
      trace_ready_d  = 1'b0;
      done_valid_d   = 1'b0;
      done_id_d      = done_id_q;
      done_err_d     = 1'b0;
      timeout_err_d  = timeout_err_q;
      issued_count_d = issued_count_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d       = S_ISSUE;
               mem_addr_d    = win_addr;
               grant_id_d    = win_id;
               last_grant_d  = win_id;
               trace_ready_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
            if (issued_count_q != '1) begin
               issued_count_d = issued_count_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            // updated wins over a coincident timeout
            if (updated) begin
               state_d      = S_IDLE;
               done_valid_d = 1'b1;
               done_id_d    = grant_id_q;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               state_d       = S_IDLE;
               done_valid_d  = 1'b1;
               done_id_d     = grant_id_q;
               done_err_d    = 1'b1;
               timeout_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         last_grant_q   <= ID_W'(NUM_REQ - 1);
         mem_addr_q     <= '0;
         grant_id_q     <= '0;
         wait_cnt_q     <= '0;
         trace_ready_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_valid_q   <= 1'b0;
         done_id_q      <= '0;
         done_err_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
         issued_count_q <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         mem_addr_q     <= mem_addr_d;
         grant_id_q     <= grant_id_d;
         wait_cnt_q     <= wait_cnt_d;
         trace_ready_q  <= trace_ready_d;
         busy_q         <= busy_d;
         done_valid_q   <= done_valid_d;
         done_id_q      <= done_id_d;
         done_err_q     <= done_err_d;
         timeout_err_q  <= timeout_err_d;
         issued_count_q <= issued_count_d;
      end
   end

   assign trace_ready  = trace_ready_q;
   assign mem_addr     = mem_addr_q;
   assign busy         = busy_q;
   assign grant_id     = grant_id_q;
   assign done_valid   = done_valid_q;
   assign done_id      = done_id_q;
   assign done_err     = done_err_q;
   assign timeout_err  = timeout_err_q;
   assign issued_count = issued_count_q;

endmodule
